// File: rtl/multicycle_controller.sv
// Multicycle controller for the 16-bit RISC datapath: fetch, decode, execute and
// data-memory write-back with wait states, timeout trap, conditional branch and HALT.
module multicycle_controller #(
  parameter int unsigned OPCODE_W    = 4,
  parameter int unsigned WE_PULSE    = 1,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic                zero_i,
  input  logic                mem_ready_i,
  output logic                load_a_o,
  output logic                load_b_o,
  output logic                load_c_o,
  output logic                load_ir_o,
  output logic                load_pc_o,
  output logic                inc_pc_o,
  output logic                mode_o,
  output logic                we_dm_o,
  output logic                sel_a_o,
  output logic                sel_b_o,
  output logic [2:0]          state_o,
  output logic                busy_o,
  output logic                halted_o,
  output logic                illegal_o
);

  localparam int unsigned PulseW   = $clog2(WE_PULSE + 1);
  localparam int unsigned TimeoutW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    StReset   = 3'd0,
    StFetch   = 3'd1,
    StDecode  = 3'd2,
    StExec    = 3'd3,
    StMemWait = 3'd4,
    StHalt    = 3'd5,
    StTrap    = 3'd6,
    StBad     = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    OpAlu, OpLoadA, OpLoadB, OpLoadC, OpJmp, OpJz, OpHalt, OpIllegal
  } op_e;

  state_e              state_q, state_d;
  logic [PulseW-1:0]   pulse_q, pulse_d;
  logic [TimeoutW-1:0] tmo_q, tmo_d;
  logic                mode_q, mode_d;
  logic [31:0]         op_ext;
  op_e                 op_class;

  always_comb begin
    op_ext   = 32'(opcode_i);
    op_class = OpIllegal;
    if (op_ext < 32'd4 || (op_ext >= 32'd8 && op_ext < 32'd16)) begin
      op_class = OpAlu;
    end else if (op_ext == 32'd4) begin
      op_class = OpLoadA;
    end else if (op_ext == 32'd5) begin
      op_class = OpLoadB;
    end else if (op_ext == 32'd6) begin
      op_class = OpLoadC;
    end else if (op_ext == 32'd7) begin
      op_class = OpJmp;
    end else if (OPCODE_W >= 5 && op_ext == 32'd16) begin
      op_class = OpJz;
    end else if (OPCODE_W >= 5 && op_ext == 32'd17) begin
      op_class = OpHalt;
    end
  end

  always_comb begin
    state_d   = state_q;
    pulse_d   = pulse_q;
    tmo_d     = tmo_q;
    mode_d    = mode_q;
    load_a_o  = 1'b0;
    load_b_o  = 1'b0;
    load_c_o  = 1'b0;
    load_ir_o = 1'b0;
    load_pc_o = 1'b0;
    inc_pc_o  = 1'b0;
    mode_o    = 1'b0;
    we_dm_o   = 1'b0;
    sel_a_o   = 1'b0;
    sel_b_o   = 1'b0;
    // en low is a stall: nothing advances and every strobe stays low
    if (en_i) begin
      unique case (state_q)
        StReset: state_d = StFetch;
        StFetch: begin
          load_ir_o = 1'b1;
          state_d   = StDecode;
        end
        StDecode: begin
          pulse_d = '0;
          if (op_class == OpIllegal)   state_d = StTrap;
          else if (op_class == OpHalt) state_d = StHalt;
          else                         state_d = StExec;
        end
        StExec: begin
          state_d = StFetch;
          unique case (op_class)
            OpLoadA: begin load_a_o = 1'b1; inc_pc_o = 1'b1; end
            OpLoadB: begin load_b_o = 1'b1; inc_pc_o = 1'b1; end
            OpLoadC: begin load_c_o = 1'b1; inc_pc_o = 1'b1; end
            OpJmp: begin
              load_pc_o = 1'b1;
              sel_a_o   = 1'b1;
              sel_b_o   = 1'b1;
            end
            OpJz: begin
              if (zero_i) begin
                load_pc_o = 1'b1;
                sel_a_o   = 1'b1;
                sel_b_o   = 1'b1;
              end else begin
                inc_pc_o = 1'b1;
              end
            end
            OpAlu: begin
              mode_o  = opcode_i[3];
              mode_d  = opcode_i[3];
              we_dm_o = 1'b1;
              if (pulse_q == PulseW'(WE_PULSE - 1)) begin
                state_d = StMemWait;
                tmo_d   = '0;
              end else begin
                state_d = StExec;
                pulse_d = pulse_q + 1'b1;
              end
            end
            default: state_d = StTrap;
          endcase
        end
        StMemWait: begin
          mode_o = mode_q;
          if (mem_ready_i) begin
            inc_pc_o = 1'b1;
            state_d  = StFetch;
          end else if (tmo_q == TimeoutW'(MEM_TIMEOUT - 1)) begin
            state_d = StTrap;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        StHalt:  state_d = StHalt;
        StTrap:  state_d = StTrap;
        default: state_d = StReset;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StReset;
      pulse_q <= '0;
      tmo_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
      tmo_q   <= tmo_d;
      mode_q  <= mode_d;
    end
  end

  assign state_o   = state_q;
  assign busy_o    = (state_q == StFetch) || (state_q == StDecode) ||
                     (state_q == StExec) || (state_q == StMemWait);
  assign halted_o  = (state_q == StHalt);
  assign illegal_o = (state_q == StTrap);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: two instances (write pulse 3 and 4) share stimulus.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst, en, zero, mem_ready;
  logic [4:0] opcode;

  always #5 clk = ~clk;

  logic la0, lb0, lc0, lir0, lpc0, inc0, mode0, we0, sa0, sb0, busy0, halt0, ill0;
  logic la1, lb1, lc1, lir1, lpc1, inc1, mode1, we1, sa1, sb1, busy1, halt1, ill1;
  logic [2:0] st0, st1;

  multicycle_controller #(.OPCODE_W(5), .WE_PULSE(3), .MEM_TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .opcode_i(opcode), .zero_i(zero),
    .mem_ready_i(mem_ready), .load_a_o(la0), .load_b_o(lb0), .load_c_o(lc0),
    .load_ir_o(lir0), .load_pc_o(lpc0), .inc_pc_o(inc0), .mode_o(mode0), .we_dm_o(we0),
    .sel_a_o(sa0), .sel_b_o(sb0), .state_o(st0), .busy_o(busy0), .halted_o(halt0),
    .illegal_o(ill0)
  );

  multicycle_controller #(.OPCODE_W(5), .WE_PULSE(4), .MEM_TIMEOUT(4)) dut_p4 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .opcode_i(opcode), .zero_i(zero),
    .mem_ready_i(mem_ready), .load_a_o(la1), .load_b_o(lb1), .load_c_o(lc1),
    .load_ir_o(lir1), .load_pc_o(lpc1), .inc_pc_o(inc1), .mode_o(mode1), .we_dm_o(we1),
    .sel_a_o(sa1), .sel_b_o(sb1), .state_o(st1), .busy_o(busy1), .halted_o(halt1),
    .illegal_o(ill1)
  );

  // Strobe vector order: {loadA, loadB, loadC, loadIR, loadPC, incPC, mode, we_DM, selA, selB}
  localparam logic [9:0] SNone = 10'h000, SLa = 10'h200, SLc = 10'h080, SLir = 10'h040;
  localparam logic [9:0] SLpc = 10'h020, SInc = 10'h010, SMode = 10'h008, SWe = 10'h004;
  localparam logic [9:0] SSa = 10'h002, SSb = 10'h001;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned we_total;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected {state, busy, halted, illegal} for a given state code
  function automatic logic [5:0] status_of(input logic [2:0] st);
    return {st, (st >= 3'd1 && st <= 3'd4), st == 3'd5, st == 3'd6};
  endfunction

  task automatic exp0(input string tag, input logic [2:0] st, input logic [9:0] strb);
    #1;
    check({tag, "/status"}, 32'({st0, busy0, halt0, ill0}), 32'(status_of(st)));
    check({tag, "/strobes"},
          32'({la0, lb0, lc0, lir0, lpc0, inc0, mode0, we0, sa0, sb0}), 32'(strb));
  endtask

  task automatic exp1(input string tag, input logic [2:0] st, input logic [9:0] strb);
    #1;
    check({tag, "/status"}, 32'({st1, busy1, halt1, ill1}), 32'(status_of(st)));
    check({tag, "/strobes"},
          32'({la1, lb1, lc1, lir1, lpc1, inc1, mode1, we1, sa1, sb1}), 32'(strb));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; opcode = 5'd4; zero = 1'b0; mem_ready = 1'b0;
    next_cycle();
    next_cycle();
    exp0("reset", 3'd0, SNone);
    rst = 1'b0;
    next_cycle(); exp0("lda_fetch", 3'd1, SLir);
    next_cycle(); exp0("lda_decode", 3'd2, SNone);
    next_cycle(); exp0("lda_exec", 3'd3, SLa | SInc);
    next_cycle(); exp0("lda_refetch", 3'd1, SLir);

    // ALU 4'b1010, ready in the third MEMWAIT cycle
    opcode = 5'b01010;
    next_cycle(); exp0("alu_decode", 3'd2, SNone);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); exp0("alu_we", 3'd3, SMode | SWe);
    end
    next_cycle(); exp0("alu_mw1", 3'd4, SMode);
    next_cycle(); exp0("alu_mw2", 3'd4, SMode);
    next_cycle(); mem_ready = 1'b1; exp0("alu_mw3", 3'd4, SMode | SInc);
    next_cycle(); mem_ready = 1'b0; exp0("alu_fetch", 3'd1, SLir);

    // JZ taken, then not taken
    opcode = 5'd16; zero = 1'b1;
    next_cycle(); exp0("jz1_decode", 3'd2, SNone);
    next_cycle(); exp0("jz1_exec", 3'd3, SLpc | SSa | SSb);
    next_cycle(); zero = 1'b0; exp0("jz1_fetch", 3'd1, SLir);
    next_cycle(); exp0("jz0_decode", 3'd2, SNone);
    next_cycle(); exp0("jz0_exec", 3'd3, SInc);
    next_cycle(); exp0("jz0_fetch", 3'd1, SLir);

    // JMP and load C
    opcode = 5'd7;
    next_cycle(); exp0("jmp_decode", 3'd2, SNone);
    next_cycle(); exp0("jmp_exec", 3'd3, SLpc | SSa | SSb);
    next_cycle(); opcode = 5'd6; exp0("jmp_fetch", 3'd1, SLir);
    next_cycle(); exp0("ldc_decode", 3'd2, SNone);
    next_cycle(); exp0("ldc_exec", 3'd3, SLc | SInc);
    next_cycle(); exp0("ldc_fetch", 3'd1, SLir);

    // ALU mode 0, ready in MEMWAIT cycle MEM_TIMEOUT is still accepted
    opcode = 5'd1;
    next_cycle(); exp0("edge_decode", 3'd2, SNone);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); exp0("edge_we", 3'd3, SWe);
    end
    for (int i = 0; i < 3; i++) begin
      next_cycle(); exp0("edge_mw", 3'd4, SNone);
    end
    next_cycle(); mem_ready = 1'b1; exp0("edge_mw4", 3'd4, SInc);
    next_cycle(); mem_ready = 1'b0; exp0("edge_fetch", 3'd1, SLir);

    // Memory timeout trap
    next_cycle(); exp0("tmo_decode", 3'd2, SNone);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); exp0("tmo_we", 3'd3, SWe);
    end
    for (int i = 0; i < 4; i++) begin
      next_cycle(); exp0("tmo_mw", 3'd4, SNone);
    end
    for (int i = 0; i < 4; i++) begin
      next_cycle(); exp0("tmo_trap", 3'd6, SNone);
    end
    rst = 1'b1;
    next_cycle(); exp0("tmo_reset", 3'd0, SNone);
    rst = 1'b0;
    next_cycle(); exp0("tmo_fetch", 3'd1, SLir);

    // HALT
    opcode = 5'd17;
    next_cycle(); exp0("halt_decode", 3'd2, SNone);
    for (int i = 0; i < 20; i++) begin
      next_cycle(); exp0("halt_hold", 3'd5, SNone);
    end
    rst = 1'b1;
    next_cycle(); exp0("halt_reset", 3'd0, SNone);
    rst = 1'b0;
    next_cycle(); opcode = 5'd20; exp0("ill_fetch", 3'd1, SLir);

    // Illegal opcode traps straight from DECODE
    next_cycle(); exp0("ill_decode", 3'd2, SNone);
    next_cycle(); exp0("ill_trap", 3'd6, SNone);
    rst = 1'b1;
    next_cycle(); exp1("ill_reset", 3'd0, SNone);
    rst = 1'b0;
    next_cycle(); opcode = 5'd9; exp1("stall_fetch", 3'd1, SLir);

    // Stall mid-way through a 4-cycle write pulse
    we_total = 0;
    next_cycle(); exp1("stall_decode", 3'd2, SNone);
    for (int i = 0; i < 2; i++) begin
      next_cycle(); exp1("stall_we_pre", 3'd3, SMode | SWe); we_total += 32'(we1);
    end
    for (int i = 0; i < 5; i++) begin
      next_cycle(); en = 1'b0; exp1("stall_hold", 3'd3, SNone); we_total += 32'(we1);
    end
    for (int i = 0; i < 2; i++) begin
      next_cycle(); en = 1'b1; exp1("stall_we_post", 3'd3, SMode | SWe); we_total += 32'(we1);
    end
    next_cycle(); exp1("stall_mw", 3'd4, SMode); we_total += 32'(we1);
    check("stall_we_total", we_total, 32'd4);

    // Reset during MEMWAIT
    rst = 1'b1;
    next_cycle();
    exp1("mw_reset", 3'd0, SNone);
    exp0("mw_reset_p3", 3'd0, SNone);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Parametrised successor to the processor's fixed 3-state controller. It sequences fetch, decode, execute and data-memory write-back for the 16-bit RISC datapath. New behaviour over the previous controller:
- configurable opcode width and we_DM pulse length (counted in clocks, not delays)
- mem_ready wait states with a timeout trap
- conditional branch and HALT on extended opcodes
- en as a stall rather than a reset

## Interface
Parameters:
- OPCODE_W, 4, opcode width (≥4); values ≥16 are extended opcodes
- WE_PULSE, 1, cycles we_DM is held per write (1..15)
- MEM_TIMEOUT, 15, max MEMWAIT cycles before trap (1..255)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  advance enable; 0 = stall
- opcode  in  OPCODE_W  instruction opcode from IR, sampled in DECODE and EXEC
- zero  in  1  ALU zero flag, sampled in EXEC
- mem_ready  in  1  data memory write-complete, sampled only in MEMWAIT
- loadA, loadB, loadC, loadIR, loadPC, incPC  out  1 each  datapath strobes
- mode  out  1  ALU mode
- we_DM  out  1  data memory write enable
- selA, selB  out  1 each  PC source selects
- state  out  3  current state encoding
- busy  out  1  1 unless in RESET, HALT or TRAP
- halted  out  1  sticky HALT flag
- illegal  out  1  sticky trap flag (illegal opcode or memory timeout)

## Operation
- States and encodings: RESET=0, FETCH=1, DECODE=2, EXEC=3, MEMWAIT=4, HALT=5, TRAP=6. Code 7 is unreachable and recovers to RESET.
- Opcode classes:
  - 0–3: ALU, mode=0.
  - 4/5/6: load A/B/C.
  - 7: JMP.
  - 8–15: ALU, mode=1.
  - 16: JZ (only if OPCODE_W≥5).
  - 17: HALT (only if OPCODE_W≥5).
  - Any other value: illegal.
- Transitions:
  - RESET→FETCH: 1 cycle.
  - FETCH: loadIR=1 for 1 cycle, →DECODE.
  - DECODE: no strobes. Illegal→TRAP, HALT→HALT, else→EXEC.
- EXEC, loads: loadX=1 and incPC=1 for 1 cycle, →FETCH.
- EXEC, JMP: loadPC=selA=selB=1 for 1 cycle, incPC=0, →FETCH.
- EXEC, JZ: if zero=1, same as JMP. If zero=0, incPC=1 only. Either way →FETCH.
- EXEC, ALU:
  - mode=opcode[3], held through EXEC and MEMWAIT.
  - we_DM=1 for WE_PULSE counted cycles, then →MEMWAIT.
- MEMWAIT:
  - mode held, we_DM=0.
  - On mem_ready=1: incPC=1 that cycle, →FETCH.
  - After MEM_TIMEOUT cycles with mem_ready=0: →TRAP.
- HALT: halted=1, all strobes 0, remain until rst.
- TRAP: illegal=1, all strobes 0, remain until rst.
- Every strobe is 0 in any cycle not listed above. mode=0 outside ALU execution; no Z drive.

## Timing
- Reset: rst high at an edge → next cycle state=RESET and every output 0 (busy, halted and illegal included). rst has priority over en and every other input.
- Stall: en=0 freezes state, the pulse counter and the timeout counter, and forces every strobe and mode to 0. Status outputs (state, busy, halted, illegal) hold. With en=1 the FSM resumes in the same state and count. A stalled we_DM pulse therefore resumes and still totals WE_PULSE high cycles.
- Latency, rising edge of FETCH to first FETCH of the next instruction:
  - Load, JMP, JZ: 3 cycles.
  - ALU: 3 + WE_PULSE + (MEMWAIT cycles − 1). Minimum 3+WE_PULSE, reached when mem_ready=1 in the first MEMWAIT cycle.
- Strobes are combinational from registered state and counters plus the sampled inputs opcode, zero and mem_ready. They are valid for the whole cycle. incPC and loadPC are never both 1.
- Timeout boundary: mem_ready=1 in MEMWAIT cycle number MEM_TIMEOUT is accepted (retire). The trap fires only if mem_ready is still 0 at the end of that cycle.
- opcode must be stable from DECODE through EXEC. A change between them is not checked.
- Counter widths cover WE_PULSE and MEM_TIMEOUT without wrap. Both reset to 0 on entry to EXEC and MEMWAIT respectively.

## Test plan
- Reset then opcode=4, en=1, rst released at cycle 0:
  - cycle 1: RESET
  - cycle 2: FETCH, loadIR=1
  - cycle 3: DECODE
  - cycle 4: EXEC, loadA=1, incPC=1
  - cycle 5: FETCH
- ALU op 4'b1010, WE_PULSE=3, mem_ready asserted 2 cycles after MEMWAIT entry:
  - we_DM high exactly 3 cycles with mode=1
  - incPC=1 in MEMWAIT cycle 3
  - FETCH next cycle
- JZ with OPCODE_W=5, opcode=16:
  - zero=1: loadPC=selA=selB=1, incPC=0.
  - zero=0: incPC=1 only.
  - Both cases re-enter FETCH after 3 cycles.
- MEM_TIMEOUT=4, mem_ready held 0: 4 MEMWAIT cycles, then state=6 with illegal=1 and busy=0. Sticky until rst; rst clears all outputs.
- Opcode 17: halted=1 and state=5, held for 20 cycles. Opcode 20 (illegal): TRAP directly from DECODE, with no EXEC strobes.
- Stall and mid-op reset:
  - en=0 for 5 cycles mid-way through a WE_PULSE=4 write: we_DM=0 while stalled, 4 high cycles total, state unchanged during the stall.
  - rst=1 asserted during MEMWAIT: RESET next cycle with all outputs 0.
